// File: rtl/dmem_pkg.sv
// Shared constants and lane-mask helper for the RV32I data memory stage.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [31:0] MMIO_ADDR = 32'hFFFF_FFF0;

  // Byte lanes touched by a store of size funct3 at byte offset a_lo.
  function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] a_lo);
    logic [3:0] m;
    m = 4'b0000;
    case (f3)
      F3_B:    m = 4'b0001 << a_lo;
      F3_H:    m = a_lo[1] ? 4'b1100 : 4'b0011;
      F3_W:    m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/load_formatter.sv
// Selects the addressed byte/halfword from a 32-bit word and sign/zero extends it.
module load_formatter
  import dmem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] rd_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[7:0];
    case (lane_i)
      2'd0: byte_sel = word_i[7:0];
      2'd1: byte_sel = word_i[15:8];
      2'd2: byte_sel = word_i[23:16];
      2'd3: byte_sel = word_i[31:24];
      default: byte_sel = word_i[7:0];
    endcase
    half_sel = lane_i[1] ? word_i[31:16] : word_i[15:0];

    rd_o = 32'h0;
    case (funct3_i)
      F3_B:    rd_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   rd_o = {24'h0, byte_sel};
      F3_H:    rd_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   rd_o = {16'h0, half_sel};
      F3_W:    rd_o = word_i;
      default: rd_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/data_memory_unit.sv
// RV32I data memory: combinational loads, byte-enabled synchronous stores, sticky fault register.
// Optional DMEM_MMIO_EN maps the word at MMIO_ADDR to the IOOut register.
module data_memory_unit
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] A,
  input  logic [31:0]   WD,
  input  logic          WE,
  input  logic          RE,
  input  logic [2:0]    funct3,
  output logic [31:0]   RD,
  output logic          AccErr,
  output logic          Fault,
  output logic [AW-1:0] FaultAddr,
`ifdef DMEM_MMIO_EN
  output logic [31:0]   IOOut,
`endif
  input  logic          FaultClear
);

  localparam int IW = $clog2(DEPTH_WORDS);

  logic [31:0]   mem_q [DEPTH_WORDS];
  logic [IW-1:0] idx;
  logic          misaligned;
  logic          illegal;
  logic          acc_err;
  logic          is_mmio;
  logic [3:0]    wr_mask;
  logic [31:0]   wdata;
  logic [31:0]   word_sel;
  logic [31:0]   fmt_rd;
  logic          fault_q, fault_d;
  logic [AW-1:0] fault_addr_q, fault_addr_d;

  assign idx = A[IW+1:2];

`ifdef DMEM_MMIO_EN
  logic [31:0] io_q, io_d;
  assign is_mmio = (A[AW-1:2] == MMIO_ADDR[AW-1:2]);
  assign IOOut   = io_q;
`else
  assign is_mmio = 1'b0;
`endif

  always_comb begin
    misaligned = ((funct3 == F3_H || funct3 == F3_HU) && A[0]) ||
                 ((funct3 == F3_W) && (A[1:0] != 2'b00));
    illegal    = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111) ||
                 (WE && (funct3 == F3_BU || funct3 == F3_HU));
    acc_err    = (RE || WE) && (misaligned || illegal);
    wr_mask    = (WE && !acc_err) ? lane_mask(funct3, A[1:0]) : 4'b0000;
    // Replicate store data so each lane picks its byte without a shifter.
    case (funct3)
      F3_B:    wdata = {4{WD[7:0]}};
      F3_H:    wdata = {2{WD[15:0]}};
      default: wdata = WD;
    endcase
  end

`ifdef DMEM_MMIO_EN
  assign word_sel = is_mmio ? io_q : mem_q[idx];
`else
  assign word_sel = mem_q[idx];
`endif

  load_formatter u_fmt (
    .word_i   (word_sel),
    .lane_i   (A[1:0]),
    .funct3_i (funct3),
    .rd_o     (fmt_rd)
  );

  assign RD     = acc_err ? 32'h0 : fmt_rd;
  assign AccErr = acc_err;

  // The array has no reset; rst only gates the write enable.
  always_ff @(posedge clk) begin
    if (!rst && !is_mmio) begin
      for (int l = 0; l < 4; l++) begin
        if (wr_mask[l]) mem_q[idx][8*l +: 8] <= wdata[8*l +: 8];
      end
    end
  end

  always_comb begin
    fault_d      = fault_q;
    fault_addr_d = fault_addr_q;
    if (acc_err) begin
      fault_d = 1'b1;
      if (!fault_q || FaultClear) fault_addr_d = A;
    end else if (FaultClear) begin
      fault_d      = 1'b0;
      fault_addr_d = '0;
    end
  end

`ifdef DMEM_MMIO_EN
  always_comb begin
    io_d = io_q;
    if (is_mmio) begin
      for (int l = 0; l < 4; l++) begin
        if (wr_mask[l]) io_d[8*l +: 8] = wdata[8*l +: 8];
      end
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
`ifdef DMEM_MMIO_EN
      io_q         <= 32'h0;
`endif
    end else begin
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
`ifdef DMEM_MMIO_EN
      io_q         <= io_d;
`endif
    end
  end

  assign Fault     = fault_q;
  assign FaultAddr = fault_addr_q;

endmodule

// File: tb/tb_data_memory_unit.sv
// Self-checking bench for data_memory_unit: directed scenarios plus a randomized model-backed load/store mix.
module tb_data_memory_unit;
  import dmem_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] A;
  logic [31:0] WD;
  logic        WE;
  logic        RE;
  logic [2:0]  funct3;
  logic [31:0] RD;
  logic        AccErr;
  logic        Fault;
  logic [31:0] FaultAddr;
  logic        FaultClear;
`ifdef DMEM_MMIO_EN
  logic [31:0] IOOut;
`endif

  int checks;
  int failures;
  logic [31:0] exp_q[$];
  logic [31:0] mdl [16];

  data_memory_unit #(.DEPTH_WORDS(1024), .AW(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .A          (A),
    .WD         (WD),
    .WE         (WE),
    .RE         (RE),
    .funct3     (funct3),
    .RD         (RD),
    .AccErr     (AccErr),
    .Fault      (Fault),
    .FaultAddr  (FaultAddr),
`ifdef DMEM_MMIO_EN
    .IOOut      (IOOut),
`endif
    .FaultClear (FaultClear)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d);
    @(negedge clk);
    A = a; funct3 = f3; WD = d; WE = 1'b1; RE = 1'b0;
    @(negedge clk);
    WE = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input logic [2:0] f3);
    @(negedge clk);
    A = a; funct3 = f3; WE = 1'b0; RE = 1'b1;
    #1;
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] a, input logic [2:0] f3);
    logic [31:0] s;
    s = w >> {a, 3'b000};
    case (f3)
      3'b000:  return {{24{s[7]}}, s[7:0]};
      3'b100:  return {24'h0, s[7:0]};
      3'b001:  return {{16{s[15]}}, s[15:0]};
      3'b101:  return {16'h0, s[15:0]};
      default: return w;
    endcase
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    #1;
    checks++;
    if (Fault !== 1'b0) begin failures++; $display("FAIL reset_fault got=%h exp=0", Fault); end
    checks++;
    if (FaultAddr !== 32'h0) begin failures++; $display("FAIL reset_faultaddr got=%h exp=0", FaultAddr); end
`ifdef DMEM_MMIO_EN
    checks++;
    if (IOOut !== 32'h0) begin failures++; $display("FAIL reset_ioout got=%h exp=0", IOOut); end
`endif
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_store_load;
    logic [31:0] la [6] = '{32'h10, 32'h11, 32'h13, 32'h10, 32'h12, 32'h12};
    logic [2:0]  lf [6] = '{F3_W, F3_B, F3_BU, F3_W, F3_H, F3_HU};
    logic [31:0] le [6] = '{32'hDEADBEEF, 32'hFFFFFFBE, 32'h000000DE, 32'hDEAABEEF, 32'hFFFFDEAA, 32'h0000DEAA};
    logic [31:0] e;
    store(32'h10, F3_W, 32'hDEADBEEF);
    for (int i = 0; i < 6; i++) begin
      if (i == 3) store(32'h12, F3_B, 32'h000000AA);
      exp_q.push_back(le[i]);
      load(la[i], lf[i]);
      e = exp_q.pop_front();
      checks++;
      if (RD !== e) begin failures++; $display("FAIL store_load[%0d] a=%h got=%h exp=%h", i, la[i], RD, e); end
    end
  endtask

  task automatic test_misaligned;
    store(32'h20, F3_W, 32'hCAFEF00D);
    @(negedge clk);
    A = 32'h22; funct3 = F3_W; WD = 32'h12345678; WE = 1'b1; RE = 1'b0;
    #1;
    checks++;
    if (AccErr !== 1'b1) begin failures++; $display("FAIL mis_accerr got=%b exp=1", AccErr); end
    checks++;
    if (RD !== 32'h0) begin failures++; $display("FAIL mis_rd_zero got=%h exp=0", RD); end
    @(negedge clk);
    WE = 1'b0;
    checks++;
    if (Fault !== 1'b1) begin failures++; $display("FAIL mis_fault got=%b exp=1", Fault); end
    checks++;
    if (FaultAddr !== 32'h22) begin failures++; $display("FAIL mis_faultaddr got=%h exp=22", FaultAddr); end
    // illegal: store with an unsigned-load encoding
    @(negedge clk);
    A = 32'h20; funct3 = F3_BU; WD = 32'h0; WE = 1'b1;
    #1;
    checks++;
    if (AccErr !== 1'b1) begin failures++; $display("FAIL illegal_sbu got=%b exp=1", AccErr); end
    @(negedge clk);
    WE = 1'b0;
    load(32'h20, 3'b011);
    checks++;
    if (AccErr !== 1'b1) begin failures++; $display("FAIL illegal_f3_011 got=%b exp=1", AccErr); end
    exp_q.push_back(32'hCAFEF00D);
    load(32'h20, F3_W);
    checks++;
    if (RD !== exp_q[0]) begin failures++; $display("FAIL mis_no_write got=%h exp=%h", RD, exp_q[0]); end
    void'(exp_q.pop_front());
    load(32'h31, F3_H);
    checks++;
    if (AccErr !== 1'b1) begin failures++; $display("FAIL lh_mis_accerr got=%b exp=1", AccErr); end
    @(negedge clk);
    RE = 1'b0;
    checks++;
    if (FaultAddr !== 32'h22 || Fault !== 1'b1) begin
      failures++; $display("FAIL first_fault_kept got=%h/%b exp=22/1", FaultAddr, Fault);
    end
    FaultClear = 1'b1;
    @(negedge clk);
    FaultClear = 1'b0;
    checks++;
    if (Fault !== 1'b0 || FaultAddr !== 32'h0) begin
      failures++; $display("FAIL fault_clear got=%b/%h exp=0/0", Fault, FaultAddr);
    end
  endtask

  task automatic test_clear_collision;
    @(negedge clk);
    A = 32'h41; funct3 = F3_W; RE = 1'b1; WE = 1'b0; FaultClear = 1'b1;
    @(negedge clk);
    RE = 1'b0; FaultClear = 1'b0;
    checks++;
    if (Fault !== 1'b1 || FaultAddr !== 32'h41) begin
      failures++; $display("FAIL clear_collision got=%b/%h exp=1/41", Fault, FaultAddr);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (Fault !== 1'b0 || FaultAddr !== 32'h0) begin
      failures++; $display("FAIL async_reset got=%b/%h exp=0/0", Fault, FaultAddr);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset_blocks_store;
    store(32'h50, F3_W, 32'h00001111);
    @(negedge clk);
    A = 32'h50; funct3 = F3_W; WD = 32'h00002222; WE = 1'b1; rst = 1'b1;
    @(negedge clk);
    WE = 1'b0; rst = 1'b0;
    exp_q.push_back(32'h00001111);
    load(32'h50, F3_W);
    checks++;
    if (RD !== exp_q[0]) begin failures++; $display("FAIL reset_blocks_store got=%h exp=%h", RD, exp_q[0]); end
    void'(exp_q.pop_front());
  endtask

  task automatic test_read_before_write;
    store(32'h60, F3_W, 32'hAAAA5555);
    @(negedge clk);
    A = 32'h60; funct3 = F3_W; WD = 32'h0BADF00D; WE = 1'b1; RE = 1'b1;
    #1;
    checks++;
    if (RD !== 32'hAAAA5555) begin failures++; $display("FAIL rbw_old got=%h exp=aaaa5555", RD); end
    @(negedge clk);
    WE = 1'b0;
    #1;
    checks++;
    if (RD !== 32'h0BADF00D) begin failures++; $display("FAIL rbw_new got=%h exp=0badf00d", RD); end
  endtask

  task automatic test_wrap;
    store(32'h1000, F3_W, 32'h00000055);
    load(32'h0, F3_W);
    checks++;
    if (RD !== 32'h00000055) begin failures++; $display("FAIL wrap got=%h exp=55", RD); end
  endtask

  task automatic test_mmio;
`ifdef DMEM_MMIO_EN
    store(32'hFFFFFFF0, F3_W, 32'h0000000F);
    checks++;
    if (IOOut !== 32'h0000000F) begin failures++; $display("FAIL mmio_sw got=%h exp=0f", IOOut); end
    load(32'h0, F3_W);
    checks++;
    if (RD !== 32'h00000055) begin failures++; $display("FAIL mmio_array_kept got=%h exp=55", RD); end
    store(32'hFFFFFFF1, F3_B, 32'h000000A0);
    checks++;
    if (IOOut !== 32'h0000A00F) begin failures++; $display("FAIL mmio_sb got=%h exp=a00f", IOOut); end
    load(32'hFFFFFFF0, F3_W);
    checks++;
    if (RD !== 32'h0000A00F) begin failures++; $display("FAIL mmio_load got=%h exp=a00f", RD); end
`else
    store(32'hFFFFFFF0, F3_W, 32'h00000077);
    load(32'hFF0, F3_W);
    checks++;
    if (RD !== 32'h00000077) begin failures++; $display("FAIL mmio_off_wrap got=%h exp=77", RD); end
`endif
  endtask

  task automatic test_random;
    logic [2:0]  lfs [5] = '{F3_B, F3_BU, F3_H, F3_HU, F3_W};
    logic [31:0] a, d, e;
    logic [2:0]  f3;
    int idx, sz, base;
    for (int i = 0; i < 16; i++) begin
      mdl[i] = $urandom;
      store(32'h100 + 32'(i * 4), F3_W, mdl[i]);
    end
    for (int n = 0; n < 80; n++) begin
      idx = $urandom_range(0, 15);
      sz  = $urandom_range(0, 2);
      a   = 32'h100 + 32'(idx * 4);
      if (sz == 0) a[1:0] = 2'($urandom_range(0, 3));
      if (sz == 1) a[1]   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        d  = $urandom;
        f3 = 3'(sz);
        base = (sz == 0) ? int'(a[1:0]) : (sz == 1) ? int'(a[1:0]) : 0;
        for (int b = 0; b < 4; b++) begin
          if ((sz == 2) || (sz == 1 && (b / 2) == (base / 2)) || (sz == 0 && b == base))
            mdl[idx][8*b +: 8] = d[8*(b - base) +: 8];
        end
        store(a, f3, d);
      end else begin
        f3 = (sz == 2) ? F3_W : lfs[sz * 2 + $urandom_range(0, 1)];
        exp_q.push_back(model_load(mdl[idx], a[1:0], f3));
        load(a, f3);
        e = exp_q.pop_front();
        checks++;
        if (RD !== e || AccErr !== 1'b0) begin
          failures++; $display("FAIL random_load a=%h f3=%b got=%h err=%b exp=%h", a, f3, RD, AccErr, e);
        end
      end
    end
    @(negedge clk);
    RE = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    A = 32'h0; WD = 32'h0; WE = 1'b0; RE = 1'b0; funct3 = F3_W; FaultClear = 1'b0;
    test_reset;
    test_store_load;
    test_misaligned;
    test_clear_collision;
    test_reset_blocks_store;
    test_read_before_write;
    test_wrap;
    test_mmio;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
